// File: rtl/traffic_sensor_conditioner_pkg.sv
// traffic_sensor_conditioner_pkg: channel state encoding and default timing constants.
package traffic_pkg;
    typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, HOLD} chan_state_t;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_FAULT_CYCLES = 1024;
endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// traffic_sensor_conditioner_if: raw detector inputs and conditioned occupancy/fault outputs.
interface traffic_sensor_conditioner_if;
    logic raw_a, raw_b, TA, TB, fault_a, fault_b;
    modport master (output raw_a, raw_b, input TA, TB, fault_a, fault_b);
    modport slave (input raw_a, raw_b, output TA, TB, fault_a, fault_b);
endinterface

// File: rtl/traffic_sensor_conditioner_channel.sv
// sensor_channel: synchroniser, debounce/hold FSM and, with TRAFFIC_SENSOR_FAULT_EN, a sticky stuck-high detector.
module sensor_channel
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int FAULT_CYCLES = DEF_FAULT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out,
    output logic fault
);
    localparam int CW = $clog2((DEB_CYCLES > HOLD_CYCLES ? DEB_CYCLES : HOLD_CYCLES) + 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || FAULT_CYCLES < 1) begin : g_bad_cycles
        $error("cycle parameters must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt, cnt_nx;
    chan_state_t state, state_nx;
    logic s, kill;

    assign s = sync[SYNC_STAGES-1];
    assign out = (state == ACTIVE) || (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            state <= IDLE;
            cnt <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: if (s) begin
                state_nx = QUAL;
                cnt_nx = CW'(1);
            end
            QUAL: if (!s) begin
                state_nx = IDLE;
                cnt_nx = '0;
            end else if (cnt == CW'(DEB_CYCLES)) begin
                state_nx = ACTIVE;
                cnt_nx = '0;
            end else cnt_nx = cnt + CW'(1);
            ACTIVE: if (!s) begin
                state_nx = HOLD;
                cnt_nx = CW'(1);
            end
            HOLD: if (s) begin
                state_nx = ACTIVE;
                cnt_nx = '0;
            end else if (cnt == CW'(HOLD_CYCLES)) begin
                state_nx = IDLE;
                cnt_nx = '0;
            end else cnt_nx = cnt + CW'(1);
            default: begin
                state_nx = IDLE;
                cnt_nx = '0;
            end
        endcase
        if (kill) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end
    end

`ifdef TRAFFIC_SENSOR_FAULT_EN
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    logic [FW-1:0] fcnt;
    logic fault_q, hit;

    // hit fires on the edge the stuck count reaches the limit, so the channel drops on that same edge
    assign hit = s && (fcnt == FW'(FAULT_CYCLES - 1));
    assign kill = fault_q | hit;
    assign fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
            fault_q <= 1'b0;
        end else begin
            fcnt <= !s ? '0 : (fcnt == FW'(FAULT_CYCLES) ? fcnt : fcnt + FW'(1));
            fault_q <= fault_q | hit;
        end
    end
`else
    assign kill = 1'b0;
    assign fault = 1'b0;
`endif
endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: two independent detector conditioning channels feeding TA/TB.
// Optional stuck-detector fault logic is built when TRAFFIC_SENSOR_FAULT_EN is defined.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int FAULT_CYCLES = DEF_FAULT_CYCLES
) (
    input logic clk,
    input logic rst,
    traffic_sensor_conditioner_if.slave bus
);
    sensor_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES), .FAULT_CYCLES(FAULT_CYCLES)
    ) u_a (
        .clk(clk), .rst(rst), .raw(bus.raw_a), .out(bus.TA), .fault(bus.fault_a)
    );

    sensor_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES), .FAULT_CYCLES(FAULT_CYCLES)
    ) u_b (
        .clk(clk), .rst(rst), .raw(bus.raw_b), .out(bus.TB), .fault(bus.fault_b)
    );
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: directed stimulus checked against a run-length model and literal expectations.
module tb_traffic_sensor_conditioner;
    localparam int SYNC = 2;
    localparam int DEB = 4;
    localparam int HOLD = 8;
    localparam int FAULT = 16;
`ifdef TRAFFIC_SENSOR_FAULT_EN
    localparam bit FEN = 1'b1;
    localparam int B_HIGH = 12;
`else
    localparam bit FEN = 1'b0;
    localparam int B_HIGH = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    traffic_sensor_conditioner_if bus();

    traffic_sensor_conditioner #(
        .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .FAULT_CYCLES(FAULT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // model: out asserts after DEB+1 consecutive high samples of s, releases after HOLD+1 consecutive lows
    logic pipe [2][SYNC];
    int hr [2];
    int lr [2];
    logic m_out [2];
    logic m_fault [2];
    logic ms;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < SYNC; k++) pipe[c][k] = 1'b0;
                hr[c] = 0;
                lr[c] = 0;
                m_out[c] = 1'b0;
                m_fault[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                ms = pipe[c][SYNC-1];
                if (ms) begin
                    hr[c] = (hr[c] < 100000) ? hr[c] + 1 : hr[c];
                    lr[c] = 0;
                end else begin
                    lr[c] = (lr[c] < 100000) ? lr[c] + 1 : lr[c];
                    hr[c] = 0;
                end
                if (FEN && hr[c] >= FAULT) m_fault[c] = 1'b1;
                if (m_fault[c]) m_out[c] = 1'b0;
                else if (!m_out[c] && hr[c] >= DEB + 1) m_out[c] = 1'b1;
                else if (m_out[c] && lr[c] >= HOLD + 1) m_out[c] = 1'b0;
                for (int k = SYNC - 1; k > 0; k--) pipe[c][k] = pipe[c][k-1];
                pipe[c][0] = (c == 0) ? bus.raw_a : bus.raw_b;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_TA", bus.TA, m_out[0]);
        chk("model_TB", bus.TB, m_out[1]);
        chk("model_fault_a", bus.fault_a, m_fault[0]);
        chk("model_fault_b", bus.fault_b, m_fault[1]);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.raw_a = 1'b0;
        bus.raw_b = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("reset_TA", bus.TA, 1'b0);
        chk("reset_TB", bus.TB, 1'b0);
        chk("reset_fault_a", bus.fault_a, 1'b0);

        bus.raw_a = 1'b1;
        bus.raw_b = 1'b1;
        tick(10);
        chk("pre_rst_TA", bus.TA, 1'b1);
        chk("pre_rst_TB", bus.TB, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_TA", bus.TA, 1'b0);
        chk("async_rst_TB", bus.TB, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(6);
        chk("post_rst_early_TA", bus.TA, 1'b0);
        tick(1);
        chk("post_rst_assert_TA", bus.TA, 1'b1);
        chk("post_rst_assert_TB", bus.TB, 1'b1);

        bus.raw_a = 1'b0;
        bus.raw_b = 1'b0;
        tick(10);
        chk("release_hold_TA", bus.TA, 1'b1);
        tick(1);
        chk("release_TA", bus.TA, 1'b0);
        chk("release_TB", bus.TB, 1'b0);

        bus.raw_a = 1'b1;
        tick(6);
        chk("assert_early_TA", bus.TA, 1'b0);
        tick(1);
        chk("assert_TA", bus.TA, 1'b1);
        chk("assert_TB_idle", bus.TB, 1'b0);

        bus.raw_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("dropout_TA", bus.TA, 1'b1);
        end
        bus.raw_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("dropout_recover_TA", bus.TA, 1'b1);
        end
        bus.raw_a = 1'b0;
        tick(12);
        chk("dropout_release_TA", bus.TA, 1'b0);

        bus.raw_a = 1'b1;
        tick(3);
        bus.raw_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("glitch_TA", bus.TA, 1'b0);
        end

        bus.raw_b = 1'b1;
        tick(B_HIGH);
        chk("b_high_TB", bus.TB, 1'b1);
        bus.raw_b = 1'b0;
        tick(10);
        chk("b_hold_TB", bus.TB, 1'b1);
        tick(1);
        chk("b_release_TB", bus.TB, 1'b0);
        chk("b_release_TA", bus.TA, 1'b0);

        bus.raw_a = 1'b1;
        tick(8);
        chk("midcnt_active_TA", bus.TA, 1'b1);
        bus.raw_a = 1'b0;
        tick(4);
        chk("midcnt_hold_TA", bus.TA, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midcnt_rst_TA", bus.TA, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            chk("midcnt_after_TA", bus.TA, 1'b0);
        end

        bus.raw_a = 1'b1;
        tick(6);
        chk("stuck_early_TA", bus.TA, 1'b0);
        tick(1);
        chk("stuck_assert_TA", bus.TA, 1'b1);
        tick(10);
        chk("stuck_pre_TA", bus.TA, 1'b1);
        chk("stuck_pre_fault_a", bus.fault_a, 1'b0);
        tick(1);
        chk("stuck_TA", bus.TA, FEN ? 1'b0 : 1'b1);
        chk("stuck_fault_a", bus.fault_a, FEN);
        tick(10);
        chk("stuck_later_TA", bus.TA, FEN ? 1'b0 : 1'b1);
        chk("stuck_later_fault_a", bus.fault_a, FEN);
        chk("stuck_fault_b", bus.fault_b, 1'b0);
        bus.raw_a = 1'b0;
        tick(20);
        chk("sticky_fault_a", bus.fault_a, FEN);
        chk("sticky_TA", bus.TA, 1'b0);
        rst = 1'b1;
        #1;
        chk("final_rst_fault_a", bus.fault_a, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        chk("final_TA", bus.TA, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
- Front-end stage directly upstream of the two-road traffic light controller.
- Turns raw, asynchronous, bouncy vehicle-detector inputs for road A and road B into the clean, stable TA/TB occupancy levels the controller's state machine consumes.
- Each channel synchronises its input, debounces it before asserting, and holds the output through short detector dropouts before releasing it.

Parameters:
- SYNC_STAGES, 2, synchroniser flop depth per channel; legal range 2..4.
- DEB_CYCLES, 4, consecutive synchronised-high cycles needed to assert; minimum 1.
- HOLD_CYCLES, 8, consecutive synchronised-low cycles needed to release; minimum 1.
- FAULT_CYCLES, 1024, stuck-high limit in cycles; used only when the optional feature is enabled.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- raw_a  in  1  unsynchronised detector, road A.
- raw_b  in  1  unsynchronised detector, road B.
- TA  out  1  conditioned occupancy, road A; feeds the controller's TA input.
- TB  out  1  conditioned occupancy, road B; feeds the controller's TB input.
- fault_a  out  1  sticky stuck-detector flag, road A.
- fault_b  out  1  sticky stuck-detector flag, road B.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset (rst) is asynchronous and active-high.
  - On reset assertion, at any time including mid-count: all synchroniser flops go to 0, both channels go to IDLE, all counters go to 0, and TA=TB=fault_a=fault_b=0 immediately.
- Channel independence:
  - The two channels are identical and fully independent.
  - Simultaneous activity on A and B is processed in parallel with no interaction.
- Synchroniser:
  - s = raw after SYNC_STAGES flops.
  - Only s is used downstream.
- Per-channel FSM (states IDLE, QUAL, ACTIVE, HOLD); registered output out=1 in ACTIVE and HOLD, else 0:
  - IDLE: s=1 -> QUAL with cnt=1; else remain.
  - QUAL:
    - s=0 -> IDLE, cnt=0; a glitch shorter than DEB_CYCLES never asserts out.
    - s=1 and cnt==DEB_CYCLES -> ACTIVE.
    - Otherwise cnt++.
  - ACTIVE: s=0 -> HOLD with cnt=1; else remain.
  - HOLD:
    - s=1 -> ACTIVE, cnt=0; the dropout is absorbed and out stays 1.
    - s=0 and cnt==HOLD_CYCLES -> IDLE.
    - Otherwise cnt++.
  - DEB_CYCLES=1 / HOLD_CYCLES=1: the transition happens on the cycle after entry if s is unchanged.
- Latency:
  - Assert: out rises exactly SYNC_STAGES+DEB_CYCLES edges after the first edge sampling raw=1, given raw stays high.
  - Release: out falls exactly SYNC_STAGES+HOLD_CYCLES edges after the first edge sampling raw=0, given raw stays low.
- Counter: width $clog2(max(DEB_CYCLES,HOLD_CYCLES)+1); it never wraps.
- Illegal state encoding: recover to IDLE next cycle with out=0.

Optional Feature:
- Macro: TRAFFIC_SENSOR_FAULT_EN.
- Enabled:
  - Each channel has a saturating counter of consecutive s=1 cycles, cleared whenever s=0.
  - When it reaches FAULT_CYCLES, fault_x goes to 1 and stays sticky until rst.
  - The channel is forced to IDLE with out=0 while fault_x=1, so a stuck detector cannot hold the controller on one road indefinitely.
- Disabled:
  - No fault counter logic is built.
  - fault_a and fault_b are tied to 0.
  - Channel behaviour is exactly as in Behaviour.

Decomposition:
- Package traffic_pkg:
  - chan_state_t enum logic [1:0] {IDLE, QUAL, ACTIVE, HOLD}.
  - Default constants for SYNC_STAGES, DEB_CYCLES, HOLD_CYCLES, FAULT_CYCLES.
- Sub-module sensor_channel:
  - Contains the synchroniser, FSM, counters and optional fault logic.
  - Instantiated twice; the top only wires raw_a/raw_b to TA/TB and fault_a/fault_b.

Test Plan (defaults SYNC_STAGES=2, DEB_CYCLES=4, HOLD_CYCLES=8):
- Reset: raw_a=raw_b=1 held while rst pulses mid-cycle -> TA=TB=0 asynchronously; after rst release, TA rises 6 edges later.
- Clean assert: raw_a 0->1 held -> TA=1 exactly 6 edges after first sampling edge; TB stays 0.
- Glitches:
  - raw_a high for 3 cycles, then low -> TA never asserts.
  - While TA=1, raw_a low for 5 cycles -> TA stays 1 throughout.
- Release: raw_b high 20 cycles, then low -> TB falls exactly 10 edges after the first low-sampling edge; TA unaffected.
- Reset mid-count: rst asserted during HOLD on A with TA=1 -> TA=0 immediately; after release with raw_a=0, TA stays 0.
- Fault (macro on, FAULT_CYCLES=16): raw_a held high -> TA=1 at edge 6; fault_a=1 and TA=0 from the edge where the stuck count reaches 16; both remain until rst. Same stimulus with macro off -> TA stays 1 and fault_a=0.
